// File: rtl/reg_mux_arb.sv
// reg_mux_arb: registered N:1 valid/ready mux with direct-select or round-robin grant.
// Define PKT_LOCK_EN to add in_last/out_last and hold the grant on one channel until its last beat.
module reg_mux_arb #(
   parameter int WIDTH = 32,
   parameter int NCH   = 4,
   localparam int SELW = $clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   input  logic [NCH-1:0]       in_valid,
   input  logic [NCH*WIDTH-1:0] in_data,
   output logic [NCH-1:0]       in_ready,
`ifdef PKT_LOCK_EN
   input  logic [NCH-1:0]       in_last,
   output logic                 out_last,
`endif
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_ch,
   input  logic                 out_ready
);
   logic [WIDTH-1:0] ch_data [NCH];
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SELW-1:0]  out_ch_q, out_ch_d, rr_ptr_q, rr_ptr_d;
   logic [SELW-1:0]  rr_gnt, idx, grant, lock_ch;
   logic             rr_ok, gnt_ok, load, xfer, last, locked;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      assign ch_data[g] = in_data[g*WIDTH +: WIDTH];
   end

   // Descending scan so the channel closest after rr_ptr is the last one written.
   always_comb begin
      rr_ok  = 1'b0;
      rr_gnt = '0;
      idx    = '0;
      for (int k = NCH; k >= 1; k--) begin
         idx = SELW'((int'(rr_ptr_q) + k) % NCH);
         if (in_valid[idx]) begin
            rr_ok  = 1'b1;
            rr_gnt = idx;
         end
      end
   end

`ifdef PKT_LOCK_EN
   typedef enum logic {IDLE, LOCKED} lk_e;
   lk_e             lk_q, lk_d;
   logic [SELW-1:0] lock_ch_q, lock_ch_d;
   logic            out_last_q, out_last_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lk_q       <= IDLE;
         lock_ch_q  <= '0;
         out_last_q <= 1'b0;
      end else begin
         lk_q       <= lk_d;
         lock_ch_q  <= lock_ch_d;
         out_last_q <= out_last_d;
      end
   end

   always_comb begin
      lk_d       = xfer ? (last ? IDLE : LOCKED) : lk_q;
      lock_ch_d  = xfer ? grant : lock_ch_q;
      out_last_d = xfer ? last : out_last_q;
   end

   assign locked   = lk_q == LOCKED;
   assign lock_ch  = lock_ch_q;
   assign last     = in_last[grant];
   assign out_last = out_last_q;
`else
   assign locked  = 1'b0;
   assign lock_ch = '0;
   assign last    = 1'b1;
`endif

   assign grant  = locked ? lock_ch : mode ? rr_gnt : sel;
   assign gnt_ok = locked ? in_valid[lock_ch] : mode ? rr_ok : (int'(sel) < NCH) && in_valid[sel];
   // Gated by rst_n so no handshake is offered while reset is held.
   assign load     = rst_n & (~out_valid_q | out_ready);
   assign xfer     = load & gnt_ok;
   assign in_ready = xfer ? NCH'(1) << grant : '0;

   always_comb begin
      out_valid_d = xfer | (out_valid_q & ~out_ready);
      out_data_d  = xfer ? ch_data[grant] : out_data_q;
      out_ch_d    = xfer ? grant : out_ch_q;
      rr_ptr_d    = (xfer & mode & last) ? grant : rr_ptr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         rr_ptr_q    <= SELW'(NCH - 1);
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
endmodule

// File: tb/tb_reg_mux_arb.sv
// tb_reg_mux_arb: directed stimulus with a transaction-level model compared every negedge.
// Channel i data is {16'hA5A5 + beats already sent by i, 16'(i)}; it advances on each accepted beat.
module tb_reg_mux_arb;
   localparam int WIDTH = 32;
   localparam int NCH   = 4;
   localparam int SELW  = 2;

   logic                 clk = 1'b0, rst_n = 1'b0, mode = 1'b0, out_ready = 1'b0;
   logic [SELW-1:0]      sel = '0;
   logic [NCH-1:0]       in_valid = '0, in_ready;
   logic [NCH*WIDTH-1:0] in_data;
   logic                 out_valid;
   logic [WIDTH-1:0]     out_data;
   logic [SELW-1:0]      out_ch;
   logic [NCH-1:0]       in_last = '1;
   logic                 out_last;

   logic [1:0]  s3_sel = 2'd3, s3_ch;
   logic [2:0]  s3_valid = 3'b111, s3_ready;
   logic        s3_out_valid, s3_last;
   logic [31:0] s3_out_data;

   int n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   reg_mux_arb #(.WIDTH(WIDTH), .NCH(NCH)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready),
`ifdef PKT_LOCK_EN
      .in_last(in_last), .out_last(out_last),
`endif
      .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready)
   );

   reg_mux_arb #(.WIDTH(32), .NCH(3)) u3 (
      .clk(clk), .rst_n(rst_n), .mode(1'b0), .sel(s3_sel), .in_valid(s3_valid),
      .in_data({32'hC2, 32'hC1, 32'hC0}), .in_ready(s3_ready),
`ifdef PKT_LOCK_EN
      .in_last(3'b111), .out_last(s3_last),
`endif
      .out_valid(s3_out_valid), .out_data(s3_out_data), .out_ch(s3_ch), .out_ready(1'b1)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model state: what the output register must hold, plus pointer and lock.
   logic             m_valid = 1'b0, m_lk = 1'b0, m_last = 1'b0;
   logic [WIDTH-1:0] m_data = '0;
   int               m_ch = 0, m_ptr = NCH - 1, m_lch = 0, mg;
   int               seq [NCH];
   logic [NCH-1:0]   exp_rdy;

   function automatic logic vbit(input logic [NCH-1:0] v, input int i);
      logic [NCH-1:0] t;
      t = v >> i;
      return t[0];
   endfunction

   function automatic logic lastb(input int i);
`ifdef PKT_LOCK_EN
      return vbit(in_last, i);
`else
      return i >= 0;
`endif
   endfunction

   function automatic logic [WIDTH-1:0] dat(input int i);
      return {16'hA5A5 + 16'(seq[i]), 16'(i)};
   endfunction

   function automatic int m_grant();
      if (!rst_n) return -1;
      if (m_lk) return vbit(in_valid, m_lch) ? m_lch : -1;
      if (!mode) return (int'(sel) < NCH && vbit(in_valid, int'(sel))) ? int'(sel) : -1;
      for (int k = 1; k <= NCH; k++)
         if (vbit(in_valid, (m_ptr + k) % NCH)) return (m_ptr + k) % NCH;
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = NCH - 1; m_lk = 1'b0; m_lch = 0; m_last = 1'b0;
         for (int i = 0; i < NCH; i++) begin
            seq[i] = 0;
            in_data[i*WIDTH +: WIDTH] <= dat(i);
         end
      end else begin
         mg = m_grant();
         if ((!m_valid || out_ready) && mg >= 0) begin
            m_valid = 1'b1; m_data = dat(mg); m_ch = mg; m_last = lastb(mg);
            if (mode && m_last) m_ptr = mg;
            m_lk = !m_last; m_lch = mg;
            seq[mg]++;
            in_data[mg*WIDTH +: WIDTH] <= dat(mg);
         end else if (out_ready) m_valid = 1'b0;
      end
   end

   always @(negedge clk) begin
      mg = m_grant();
      exp_rdy = (rst_n && (!m_valid || out_ready) && mg >= 0) ? NCH'(1) << mg : '0;
      check("m_out_valid", 64'(out_valid), 64'(m_valid));
      check("m_out_data", 64'(out_data), 64'(m_data));
      check("m_out_ch", 64'(out_ch), 64'(m_ch));
      check("m_in_ready", 64'(in_ready), 64'(exp_rdy));
`ifdef PKT_LOCK_EN
      check("m_out_last", 64'(out_last), 64'(m_last));
`endif
   end

   task automatic drive(input logic m, input logic [NCH-1:0] v, input logic rdy);
      @(posedge clk);
      #1 mode = m; in_valid = v; out_ready = rdy;
      @(negedge clk);
   endtask

   initial begin
      mode = 1'b1; in_valid = '1; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_data", 64'(out_data), 64'd0);
      check("rst_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("first_ready", 64'(in_ready), 64'b0001);
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, k == 7 ? 4'b0000 : 4'b1111, k != 7);
         check("rr_all_ch", 64'(out_ch), 64'(k % 4));
         check("rr_all_valid", 64'(out_valid), 64'd1);
         if (k == 0) check("rr_first_data", 64'(out_data), 64'hA5A5_0000);
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_valid", 64'(out_valid), 64'd0);
      check("async_data", 64'(out_data), 64'd0);
      check("async_ch", 64'(out_ch), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1; mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
      @(negedge clk);
      check("dir_ready", 64'(in_ready), 64'b0100);
      drive(1'b0, 4'b0000, 1'b1);
      check("dir_data", 64'(out_data), 64'hA5A5_0002);
      check("dir_ch", 64'(out_ch), 64'd2);
      drive(1'b1, 4'b1010, 1'b1);
      check("rr13_ready", 64'(in_ready), 64'b0010);
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, k == 3 ? 4'b1111 : 4'b1010, k != 3);
         check("rr13_ch", 64'(out_ch), k % 2 ? 64'd3 : 64'd1);
      end
      for (int j = 0; j < 5; j++) begin
         drive(1'b1, 4'b1111, 1'b0);
         check("bp_ch", 64'(out_ch), 64'd3);
         check("bp_data", 64'(out_data), 64'hA5A6_0003);
         check("bp_valid", 64'(out_valid), 64'd1);
         check("bp_ready", 64'(in_ready), 64'd0);
      end
      drive(1'b1, 4'b1111, 1'b1);
      check("rel_ready", 64'(in_ready), 64'b0001);
      for (int j = 0; j < 4; j++) begin
         drive(1'b1, j == 3 ? 4'b0000 : 4'b1111, 1'b1);
         check("rel_ch", 64'(out_ch), 64'(j));
         case (j)
            0: check("rel_data", 64'(out_data), 64'hA5A5_0000);
            1: check("rel_data", 64'(out_data), 64'hA5A7_0001);
            2: check("rel_data", 64'(out_data), 64'hA5A6_0002);
            default: check("rel_data", 64'(out_data), 64'hA5A7_0003);
         endcase
      end
`ifdef PKT_LOCK_EN
      in_last = 4'b0001;
      drive(1'b1, 4'b0010, 1'b1);
      check("lk_ready0", 64'(in_ready), 64'b0010);
      drive(1'b1, 4'b0011, 1'b1);
      check("lk_b1_ch", 64'(out_ch), 64'd1);
      check("lk_b1_last", 64'(out_last), 64'd0);
      check("lk_ready1", 64'(in_ready), 64'b0010);
      drive(1'b1, 4'b0011, 1'b1);
      check("lk_b2_ch", 64'(out_ch), 64'd1);
      check("lk_b2_last", 64'(out_last), 64'd0);
      in_last = 4'b0011;
      drive(1'b1, 4'b0011, 1'b1);
      check("lk_b3_ch", 64'(out_ch), 64'd1);
      check("lk_b3_last", 64'(out_last), 64'd1);
      in_last = 4'b0001;
      drive(1'b1, 4'b0000, 1'b1);
      check("lk_after_ch", 64'(out_ch), 64'd0);
      in_last = 4'b1111;
`endif
      @(negedge clk);
      check("n3_selhi_ready", 64'(s3_ready), 64'd0);
      check("n3_selhi_valid", 64'(s3_out_valid), 64'd0);
      @(posedge clk);
      #1 s3_sel = 2'd2;
      @(negedge clk);
      check("n3_sel2_ready", 64'(s3_ready), 64'b100);
      @(posedge clk);
      #1 s3_valid = 3'b000;
      @(negedge clk);
      check("n3_ch", 64'(s3_ch), 64'd2);
      check("n3_data", 64'(s3_out_data), 64'hC2);
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
